sirv_gnrl_skid_buf: RTL and testbench



---
 rtl/sirv_gnrl_skid_buf.sv | 111 +++++++++++
 tb/tb_sirv_gnrl_skid_buf.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sirv_gnrl_skid_buf.sv
// Two-entry valid/ready skid buffer: registers both the forward path
// (o_vld/o_dat) and the backward path (i_rdy) between producer and consumer.
// With CHECK_X=1 the valid-qualified output is checked for X in simulation.
module sirv_gnrl_skid_buf #(
    parameter int unsigned DW      = 32,
    parameter bit          CHECK_X = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [1:0]    o_cnt
);

    // Occupancy-encoded states: the encoding is the entry count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] main_d;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] skid_d;
    logic          in_hs;
    logic          out_hs;

    // i_rdy depends only on the state register and rst, never on o_rdy
    assign i_rdy  = (state_q != TWO) & ~rst;
    assign o_vld  = (state_q != EMPTY);
    assign o_dat  = main_q;
    assign o_cnt  = 2'(state_q);

    assign in_hs  = i_vld & i_rdy;
    assign out_hs = o_vld & o_rdy;

    // Control state: occupancy tracking, synchronously reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) state_q <= ONE;
                end
                ONE: begin
                    if (in_hs && !out_hs)      state_q <= TWO;
                    else if (!in_hs && out_hs) state_q <= EMPTY;
                end
                TWO: begin
                    if (out_hs) state_q <= ONE;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Data next-state: i_dat is only captured on an input handshake, so X on
    // an idle bus never lands in storage; skid always holds the younger beat
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_hs) main_d = i_dat;
            end
            ONE: begin
                if (in_hs && out_hs)      main_d = i_dat;
                else if (in_hs && !out_hs) skid_d = i_dat;
            end
            TWO: begin
                if (out_hs) main_d = skid_q;
            end
            default: ;
        endcase
    end

    // Data registers are intentionally not reset
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
    generate
        if (CHECK_X) begin : g_xchk
            logic [DW:0] xchk_in;

            // Data is masked while invalid so stale/unreset contents are legal
            assign xchk_in = {o_vld, (o_vld ? o_dat : {DW{1'b0}})};

            // Mid-cycle X check so a bad beat is flagged in the cycle it appears
            always @(negedge clk) begin
                if (!rst) begin
                    assert (!$isunknown(xchk_in))
                    else $fatal(1, "sirv_gnrl_skid_buf: X on valid-qualified output");
                end
            end
        end
    endgenerate
`endif
`endif

endmodule

// File: tb/tb_sirv_gnrl_skid_buf.sv
// Bench for sirv_gnrl_skid_buf: directed scenarios plus random traffic,
// checked against a capacity-2 FIFO model held as a queue.
module tb_sirv_gnrl_skid_buf;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [1:0]    o_cnt;

    int            errors = 0;
    int            checks = 0;
    int            popped = 0;
    logic [DW-1:0] exp_q[$];
    bit            armed  = 1'b0;
    bit            acc;
    bit            pop;

    sirv_gnrl_skid_buf #(
        .DW      (DW),
        .CHECK_X (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .i_dat (i_dat),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .o_cnt (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Inputs change just after the rising edge and stay put until the next one
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
        @(posedge clk);
        #1;
        i_vld = v;
        i_dat = d;
        o_rdy = r;
        rst   = rs;
    endtask

    // Monitor/scoreboard: mid-cycle, compare the DUT against the FIFO model,
    // then advance the model by what the coming rising edge will do
    always @(negedge clk) begin
        if (armed) begin
            check("i_rdy", DW'(i_rdy), DW'((exp_q.size() < 2) && !rst));
            check("o_vld", DW'(o_vld), DW'(exp_q.size() != 0));
            check("o_cnt", DW'(o_cnt), DW'(exp_q.size()));
            if (exp_q.size() != 0) check("o_dat", o_dat, exp_q[0]);
        end
        if (rst) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            acc = (exp_q.size() < 2) && i_vld;
            pop = (exp_q.size() != 0) && o_rdy;
            if (pop) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (acc) exp_q.push_back(i_dat);
        end
    end

    initial begin
        rst   = 1'b1;
        i_vld = 1'b0;
        i_dat = 'x;
        o_rdy = 1'b0;

        // Reset held for three edges, then released
        step(1'b0, 'x, 1'b0, 1'b1);
        step(1'b0, 'x, 1'b0, 1'b1);
        step(1'b0, 'x, 1'b0, 1'b0);
        step(1'b0, 'x, 1'b0, 1'b0);

        // Back-to-back streaming with the consumer always ready
        step(1'b1, 32'h11, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);

        // Fill under backpressure, third beat refused, then drain in order
        step(1'b1, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b1, 1'b0);
        step(1'b1, 32'hA2, 1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0);

        // Simultaneous accept and emit while holding one entry
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while full: both beats are discarded
        step(1'b1, 32'hB0, 1'b0, 1'b0);
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 32'hB2, 1'b0, 1'b1);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);

        // Unknown data on an idle bus must not be captured
        step(1'b0, 'x,    1'b0, 1'b0);
        step(1'b0, 'x,    1'b1, 1'b0);
        step(1'b1, 32'h7, 1'b0, 1'b0);
        step(1'b0, 'x,    1'b0, 1'b0);
        step(1'b0, 'x,    1'b1, 1'b0);

        // Random traffic with occasional resets
        repeat (3000) begin
            step(1'b1 & ($urandom_range(0, 2) != 0),
                 DW'($urandom),
                 1'b1 & ($urandom_range(0, 2) != 0),
                 1'b1 & ($urandom_range(0, 63) == 0));
        end

        // Drain
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("beats_delivered", DW'(popped > 100), DW'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
